// File: rtl/sensor_rx_pkg.sv
// sensor_rx_pkg: shared packet field positions, channel count and receiver FSM states
package sensor_rx_pkg;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 4;
    localparam int ADDR_MSB = 3;
    localparam int ADDR_LSB = 1;
    localparam int PAR_BIT  = 0;
    localparam int NUM_CH   = 8;
    typedef enum logic {HUNT, RUN} state_t;
endpackage

// File: rtl/sensor_rx_parity_eval.sv
// rx_parity_eval: even-parity check of a 12-bit sensor packet
//   pkt  : full packet, parity bit included
//   good : high when the XOR over all packet bits is 0
module rx_parity_eval (
    input  logic [11:0] pkt,
    output logic        good
);
    assign good = ~^pkt;
endmodule

// File: rtl/sensor_packet_receiver.sv
// sensor_packet_receiver: checks parity/address sequence of link packets and fills per-channel holding registers
//   clk, rst_n           : clock, asynchronous active-low reset
//   pkt_valid, pkt_in    : one packet per valid cycle ([11:4] data, [3:1] addr, [0] parity)
//   sensor_out0..7       : last good data per channel
//   chan_valid           : channels written with good data in the current frame
//   frame_done           : pulse when the addr-7 slot of a frame closes
//   parity_error, seq_error : error pulses
//   err_count            : saturating error total
//   synced               : high while locked to the frame sequence
module sensor_packet_receiver
    import sensor_rx_pkg::*;
#(
    parameter int ERR_W   = 8,
    parameter int MAX_BAD = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pkt_valid,
    input  logic [11:0]      pkt_in,
    output logic [7:0]       sensor_out0,
    output logic [7:0]       sensor_out1,
    output logic [7:0]       sensor_out2,
    output logic [7:0]       sensor_out3,
    output logic [7:0]       sensor_out4,
    output logic [7:0]       sensor_out5,
    output logic [7:0]       sensor_out6,
    output logic [7:0]       sensor_out7,
    output logic [7:0]       chan_valid,
    output logic             frame_done,
    output logic             parity_error,
    output logic             seq_error,
    output logic [ERR_W-1:0] err_count,
    output logic             synced
);
    localparam int BW = $clog2(MAX_BAD + 1);

    state_t          state;
    logic [2:0]      exp_addr;
    logic [BW-1:0]   bad_cnt;
    logic [7:0]      sens [NUM_CH];
    logic            good;
    logic [7:0]      data;
    logic [2:0]      addr;
    logic            is_run;
    logic            match;

    rx_parity_eval u_par (.pkt(pkt_in), .good(good));

    assign data   = pkt_in[DATA_MSB:DATA_LSB];
    assign addr   = pkt_in[ADDR_MSB:ADDR_LSB];
    assign is_run = state == RUN;
    assign match  = addr == exp_addr;
    assign synced = is_run;

    assign sensor_out0 = sens[0];
    assign sensor_out1 = sens[1];
    assign sensor_out2 = sens[2];
    assign sensor_out3 = sens[3];
    assign sensor_out4 = sens[4];
    assign sensor_out5 = sens[5];
    assign sensor_out6 = sens[6];
    assign sensor_out7 = sens[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            exp_addr     <= 3'd0;
            bad_cnt      <= '0;
            chan_valid   <= 8'h00;
            frame_done   <= 1'b0;
            parity_error <= 1'b0;
            seq_error    <= 1'b0;
            err_count    <= '0;
            for (int i = 0; i < NUM_CH; i++) sens[i] <= 8'h00;
        end else begin
            parity_error <= pkt_valid && !good;
            seq_error    <= pkt_valid && good && is_run && !match;
            // the addr-7 slot closes whether it was good or lost to a parity failure
            frame_done   <= pkt_valid && is_run && exp_addr == 3'd7 && (!good || match);
            // parity is checked first, so a packet adds at most one error
            if (pkt_valid && (!good || (is_run && !match)) && !(&err_count))
                err_count <= err_count + 1'b1;
            if (pkt_valid) begin
                if (!good) begin
                    if (is_run) begin
                        exp_addr <= exp_addr + 3'd1;
                        if (bad_cnt == BW'(MAX_BAD - 1)) begin
                            state   <= HUNT;
                            bad_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                end else if (addr == 3'd0) begin
                    // any good addr-0 packet is a frame start: lock from HUNT, in-order or resync in RUN
                    sens[0]    <= data;
                    chan_valid <= 8'h01;
                    exp_addr   <= 3'd1;
                    state      <= RUN;
                    bad_cnt    <= '0;
                end else if (is_run) begin
                    if (match) begin
                        sens[addr]       <= data;
                        chan_valid[addr] <= 1'b1;
                        exp_addr         <= exp_addr + 3'd1;
                    end else begin
                        state <= HUNT;
                    end
                    bad_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sensor_packet_receiver.sv
// tb_sensor_packet_receiver: directed checks of the receiver, with a second ERR_W=2 instance for saturation
module tb_sensor_packet_receiver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [11:0] pkt_in = 12'h000;
    logic [7:0]  so [8];
    logic [7:0]  chan_valid;
    logic        frame_done, parity_error, seq_error, synced;
    logic [7:0]  err_count;
    logic [7:0]  so2 [8];
    logic [7:0]  chan_valid2;
    logic        frame_done2, parity_error2, seq_error2, synced2;
    logic [1:0]  err_count2;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    sensor_packet_receiver u_dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_in(pkt_in),
        .sensor_out0(so[0]), .sensor_out1(so[1]), .sensor_out2(so[2]), .sensor_out3(so[3]),
        .sensor_out4(so[4]), .sensor_out5(so[5]), .sensor_out6(so[6]), .sensor_out7(so[7]),
        .chan_valid(chan_valid), .frame_done(frame_done), .parity_error(parity_error),
        .seq_error(seq_error), .err_count(err_count), .synced(synced)
    );

    sensor_packet_receiver #(.ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_in(pkt_in),
        .sensor_out0(so2[0]), .sensor_out1(so2[1]), .sensor_out2(so2[2]), .sensor_out3(so2[3]),
        .sensor_out4(so2[4]), .sensor_out5(so2[5]), .sensor_out6(so2[6]), .sensor_out7(so2[7]),
        .chan_valid(chan_valid2), .frame_done(frame_done2), .parity_error(parity_error2),
        .seq_error(seq_error2), .err_count(err_count2), .synced(synced2)
    );

    function automatic logic [11:0] mk(input logic [2:0] a, input logic [7:0] d, input logic flip);
        return {d, a, (^{d, a}) ^ flip};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] p);
        pkt_valid = 1'b1;
        pkt_in = p;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_synced", synced, 0);
        chk("rst_chan_valid", chan_valid, 8'h00);
        chk("rst_err", err_count, 0);
        chk("rst_so0", so[0], 0);
        chk("rst_pulses", {frame_done, parity_error, seq_error}, 0);
        chk("encode_a5", mk(3'd0, 8'hA5, 1'b0), 12'hA50);
        #10 rst_n = 1'b1;
        idle();
        chk("idle_hunt", synced, 0);

        for (int n = 0; n < 8; n++) begin
            send(mk(3'(n), 8'h10 + 8'(n), 1'b0));
            chk("f1_synced", synced, 1);
            chk("f1_frame_done", frame_done, n == 7);
            chk("f1_sensor", so[n], 8'h10 + 8'(n));
        end
        chk("f1_chan_valid", chan_valid, 8'hFF);
        idle();
        chk("f1_done_once", frame_done, 0);
        chk("f1_hold", chan_valid, 8'hFF);

        send(mk(3'd0, 8'h20, 1'b0));
        chk("f2_new_frame", chan_valid, 8'h01);
        send(mk(3'd1, 8'h21, 1'b0));
        send(mk(3'd2, 8'h22, 1'b0));
        send(mk(3'd3, 8'h33, 1'b1));
        chk("par_pulse", parity_error, 1);
        chk("par_err", err_count, 1);
        chk("par_so3_kept", so[3], 8'h13);
        chk("par_cv", chan_valid, 8'h07);
        chk("par_synced", synced, 1);
        send(mk(3'd4, 8'h24, 1'b0));
        chk("par_next_ok", so[4], 8'h24);
        chk("par_next_cv", chan_valid, 8'h17);
        chk("par_pulse_end", parity_error, 0);
        send(mk(3'd5, 8'h25, 1'b0));
        send(mk(3'd6, 8'h26, 1'b0));
        send(mk(3'd7, 8'h27, 1'b0));
        chk("f2_done", frame_done, 1);
        chk("f2_cv", chan_valid, 8'hF7);

        send(mk(3'd0, 8'h30, 1'b0));
        send(mk(3'd1, 8'h31, 1'b0));
        send(mk(3'd2, 8'h32, 1'b0));
        send(mk(3'd5, 8'h35, 1'b0));
        chk("seq_pulse", seq_error, 1);
        chk("seq_synced", synced, 0);
        chk("seq_err", err_count, 2);
        chk("seq_so5_kept", so[5], 8'h25);
        chk("seq_cv", chan_valid, 8'h07);
        send(mk(3'd6, 8'h36, 1'b0));
        chk("hunt_ign_so6", so[6], 8'h26);
        chk("hunt_ign_seq", seq_error, 0);
        send(mk(3'd7, 8'h37, 1'b0));
        chk("hunt_no_done", frame_done, 0);
        chk("hunt_ign_err", err_count, 2);
        send(mk(3'd0, 8'h40, 1'b0));
        chk("resync", synced, 1);
        chk("resync_cv", chan_valid, 8'h01);
        chk("resync_so0", so[0], 8'h40);

        for (int n = 1; n <= 3; n++) begin
            send(mk(3'(n), 8'h50, 1'b1));
            chk("bad_run_pulse", parity_error, 1);
            chk("bad_run_synced", synced, n < 3);
        end
        chk("bad_run_err", err_count, 5);
        chk("sat_err2", err_count2, 2'b11);
        send(mk(3'd2, 8'h60, 1'b1));
        chk("hunt_par_pulse", parity_error, 1);
        chk("hunt_par_err", err_count, 6);
        chk("sat_err2_hold", err_count2, 2'b11);

        send(mk(3'd0, 8'h70, 1'b0));
        for (int n = 1; n < 7; n++) send(mk(3'(n), 8'h70 + 8'(n), 1'b0));
        send(mk(3'd7, 8'h77, 1'b1));
        chk("bad7_done", frame_done, 1);
        chk("bad7_par", parity_error, 1);
        chk("bad7_cv", chan_valid, 8'h7F);
        chk("bad7_so7", so[7], 8'h27);

        send(mk(3'd0, 8'h80, 1'b0));
        send(mk(3'd1, 8'h81, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_synced", synced, 0);
        chk("arst_cv", chan_valid, 0);
        chk("arst_so1", so[1], 0);
        chk("arst_err", err_count, 0);
        chk("arst_err2", err_count2, 0);
        send(mk(3'd3, 8'h99, 1'b1));
        chk("arst_pulses", {frame_done, parity_error, seq_error}, 0);
        chk("arst_hold_err", err_count, 0);
        #2 rst_n = 1'b1;
        send(mk(3'd1, 8'h91, 1'b0));
        chk("post_rst_hunt", synced, 0);
        chk("post_rst_so1", so[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
